// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the divider family (clock divider, PWM, scan blocks).
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    // High-phase length of an N-cycle period: ceil(N/2), extra cycle goes high for odd N.
    function automatic logic [63:0] high_len(input logic [63:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clock_divider_prog.sv
// Programmable clock divider: registered square wave plus one-cycle tick per period,
// with runtime divisor reload at period boundaries, enable, sync restart and load error flag.
module clock_divider_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned     WIDTH       = 32,
    parameter longint unsigned DEFAULT_DIV = 1_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_sync_clear,
    input  logic             i_div_load,
    input  logic [WIDTH-1:0] i_div_value,
    output logic             o_clk,
    output logic             o_tick,
    output logic [WIDTH-1:0] o_div_active,
    output logic             o_div_err
);

    if (DEFAULT_DIV < DIV_MIN || (DEFAULT_DIV >> WIDTH) != 0) begin : g_bad_default
        $error("clock_divider_prog: DEFAULT_DIV must be >= 2 and < 2**WIDTH");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             wrap;
    logic [WIDTH-1:0] cnt_next;

    always_comb begin
        load_ok  = i_div_load && (i_div_value >= WIDTH'(DIV_MIN));
        wrap     = (cnt_q == div_q - WIDTH'(1));
        cnt_next = wrap ? '0 : cnt_q + WIDTH'(1);

        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        err_d    = i_div_load && !load_ok;

        if (load_ok) begin
            pend_d   = i_div_value;
            pend_v_d = 1'b1;
        end

        if (i_sync_clear) begin
            cnt_d  = '0;
            clk_d  = 1'b1;
            tick_d = 1'b1;
            // A same-cycle load bypasses the shadow register and wins over an older pending value.
            if (load_ok) begin
                div_d    = i_div_value;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                div_d    = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (i_enable) begin
            cnt_d = cnt_next;
            // A load landing on the wrap edge stays pending for the following period.
            if (wrap && pend_v_q) begin
                div_d    = pend_q;
                pend_v_d = load_ok;
            end
            clk_d  = (cnt_next < WIDTH'(high_len(64'(div_d))));
            tick_d = wrap;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q    <= WIDTH'(DEFAULT_DIV - 1);
            div_q    <= WIDTH'(DEFAULT_DIV);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    assign o_clk        = clk_q;
    assign o_tick       = tick_q;
    assign o_div_active = div_q;
    assign o_div_err    = err_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed scoreboard bench for clock_divider_prog at WIDTH=8, DEFAULT_DIV=4.
module tb_clock_divider_prog;

    typedef struct {
        bit       rst, en, clr, ld;
        bit [7:0] val;
        bit       eclk, etick;
        bit [7:0] eact;
        bit       eerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [7:0] val = '0;
    logic       o_clk, o_tick, o_err;
    logic [7:0] o_act;

    vec_t vecs[$];
    vec_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   vidx   = 0;

    clock_divider_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_sync_clear (clr),
        .i_div_load   (ld),
        .i_div_value  (val),
        .o_clk        (o_clk),
        .o_tick       (o_tick),
        .o_div_active (o_act),
        .o_div_err    (o_err)
    );

    always #5 clk = ~clk;

    task automatic add(input bit r, input bit e, input bit c, input bit l, input int v,
                       input bit xc, input bit xt, input int xa, input bit xe);
        vec_t t;
        t.rst = r; t.en = e; t.clr = c; t.ld = l; t.val = 8'(v);
        t.eclk = xc; t.etick = xt; t.eact = 8'(xa); t.eerr = xe;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec %0d got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output set.
    initial begin
        vec_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                x = expq.pop_front();
                chk("o_clk",        vidx, int'(o_clk),  int'(x.eclk));
                chk("o_tick",       vidx, int'(o_tick), int'(x.etick));
                chk("o_div_active", vidx, int'(o_act),  int'(x.eact));
                chk("o_div_err",    vidx, int'(o_err),  int'(x.eerr));
                vidx++;
            end
        end
    end

    initial begin
        //   rst en clr ld val   clk tick act err
        add(1, 0, 0, 0, 0,   0, 0, 4, 0);   // reset state
        // free-running divide by 4: tick on cycles 1,5,9
        add(0, 1, 0, 0, 0,   1, 1, 4, 0);
        add(0, 1, 0, 0, 0,   1, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   1, 1, 4, 0);
        add(0, 1, 0, 0, 0,   1, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   1, 1, 4, 0);
        add(0, 1, 0, 0, 0,   1, 0, 4, 0);   // cnt=1
        add(0, 1, 0, 1, 5,   0, 0, 4, 0);   // load 5 mid-period
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   1, 1, 5, 0);   // applied at wrap
        add(0, 1, 0, 0, 0,   1, 0, 5, 0);
        add(0, 1, 0, 0, 0,   1, 0, 5, 0);
        add(0, 1, 0, 0, 0,   0, 0, 5, 0);
        add(0, 1, 0, 0, 0,   0, 0, 5, 0);
        add(0, 1, 0, 0, 0,   1, 1, 5, 0);
        add(0, 1, 0, 0, 0,   1, 0, 5, 0);
        add(0, 1, 0, 0, 0,   1, 0, 5, 0);
        add(0, 1, 0, 0, 0,   0, 0, 5, 0);
        add(0, 1, 0, 0, 0,   0, 0, 5, 0);
        add(1, 1, 0, 0, 0,   0, 0, 4, 0);   // back to divide by 4
        // illegal loads 0 and 1
        add(0, 1, 0, 0, 0,   1, 1, 4, 0);
        add(0, 1, 0, 1, 0,   1, 0, 4, 1);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 1, 1,   0, 0, 4, 1);
        add(0, 1, 0, 0, 0,   1, 1, 4, 0);
        add(0, 1, 0, 0, 0,   1, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);   // cnt=2
        // enable dropped for 3 cycles
        add(0, 0, 0, 0, 0,   0, 0, 4, 0);
        add(0, 0, 0, 0, 0,   0, 0, 4, 0);
        add(0, 0, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   1, 1, 4, 0);
        // load 6 with sync clear
        add(0, 1, 1, 1, 6,   1, 1, 6, 0);
        add(0, 1, 0, 0, 0,   1, 0, 6, 0);
        add(0, 1, 0, 0, 0,   1, 0, 6, 0);
        add(0, 1, 0, 0, 0,   0, 0, 6, 0);
        add(0, 1, 0, 0, 0,   0, 0, 6, 0);
        add(0, 1, 0, 0, 0,   0, 0, 6, 0);
        add(0, 1, 0, 0, 0,   1, 1, 6, 0);
        add(0, 1, 0, 0, 0,   1, 0, 6, 0);
        // sync clear while disabled, then hold
        add(0, 0, 1, 0, 0,   1, 1, 6, 0);
        add(0, 0, 0, 0, 0,   1, 0, 6, 0);
        // pending divisor applied immediately by sync clear
        add(0, 1, 0, 1, 3,   1, 0, 6, 0);
        add(0, 0, 1, 0, 0,   1, 1, 3, 0);
        add(0, 1, 0, 0, 0,   1, 0, 3, 0);
        add(0, 1, 0, 0, 0,   0, 0, 3, 0);
        add(0, 1, 0, 0, 0,   1, 1, 3, 0);
        // load 7 then reset before wrap
        add(0, 1, 0, 1, 7,   1, 0, 3, 0);
        add(1, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   1, 1, 4, 0);
        add(0, 1, 0, 0, 0,   1, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   1, 1, 4, 0);
        // minimum divisor 2
        add(0, 1, 0, 1, 2,   1, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   0, 0, 4, 0);
        add(0, 1, 0, 0, 0,   1, 1, 2, 0);
        add(0, 1, 0, 0, 0,   0, 0, 2, 0);
        add(0, 1, 0, 0, 0,   1, 1, 2, 0);
        add(0, 1, 0, 0, 0,   0, 0, 2, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            en  = vecs[i].en;
            clr = vecs[i].clr;
            ld  = vecs[i].ld;
            val = vecs[i].val;
            expq.push_back(vecs[i]);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; clr = 1'b0; ld = 1'b0; val = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

Programmable clock divider producing a registered square wave and a one-cycle tick per output period from a single system clock. It generalises the fixed divide-by-constant divider: the divisor width is parametrised, the divisor can be changed at runtime without glitches, and the block adds an enable, a synchronous phase restart and an error flag for illegal divisors. It sits between the board clock and slow logic such as counters, display scanners and debouncers. Downstream logic uses `o_tick` as a clock enable; `o_clk` is for LEDs and pins only.

## Interface
- `WIDTH`, 32: width of the divisor and internal counter.
- `DEFAULT_DIV`, 1_000_000: output period in `i_clk` cycles after reset. Must be ≥ 2 and < 2^WIDTH; elaboration error otherwise.

Ports:
- `i_clk` in 1: system clock; the only clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_enable` in 1: counting enable. When low the divider freezes.
- `i_sync_clear` in 1: restarts the period on the next edge.
- `i_div_load` in 1: one-cycle strobe that requests a new divisor.
- `i_div_value` in WIDTH: requested divisor N, sampled when `i_div_load`=1.
- `o_clk` out 1: registered divided clock.
- `o_tick` out 1: one-cycle pulse at the start of each period.
- `o_div_active` out WIDTH: divisor currently in force.
- `o_div_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- State:
  - `cnt` (WIDTH): runs 0..N-1, where N = `o_div_active`.
  - `pend`: pending divisor register.
  - `pend_v`: pending-valid bit.
  - H = ceil(N/2) = N - floor(N/2).
- Reset:
  - `cnt` = DEFAULT_DIV-1 and `o_div_active` = DEFAULT_DIV.
  - `pend_v` = 0.
  - `o_clk`, `o_tick` and `o_div_err` = 0.
- Enabled edge (`i_enable`=1, no clear):
  - `cnt_next` = (`cnt` == N-1) ? 0 : `cnt`+1.
  - `o_clk` <= (`cnt_next` < H).
  - `o_tick` <= (`cnt_next` == 0).
- Disabled edge:
  - `cnt` and `o_clk` hold.
  - `o_tick` <= 0.
- Waveform: `o_clk` is high for H cycles and low for N-H cycles. For odd N the extra cycle is in the high phase. One tick occurs per N enabled cycles, and it coincides with the first high cycle of `o_clk`.
- Divisor load:
  - If `i_div_value` ≥ 2: `pend` <= value and `pend_v` <= 1. A newer load overwrites an older pending one.
  - If `i_div_value` < 2: the load is ignored, `o_div_err` <= 1 for one cycle, and `pend`/`pend_v` are unchanged.
- Apply point: on the enabled edge where `cnt` wraps (N-1 → 0) with `pend_v`=1:
  - `o_div_active` <= `pend` and `pend_v` <= 0.
  - H for the new period is computed from the new divisor.
  - The period in progress always completes at its old length, so `o_clk` never produces a runt pulse.
- Sync clear (`i_sync_clear`=1), applied regardless of `i_enable`:
  - `cnt` <= 0, `o_clk` <= 1, `o_tick` <= 1.
  - Any pending divisor is applied immediately.
  - If `i_div_load` is high with a valid value in the same cycle, that value becomes active directly.
- Priority: reset > sync_clear > enable/wrap. A load is accepted in any non-reset cycle, including while disabled.
- Arithmetic: all compares are unsigned WIDTH-bit. N-1 never underflows, because N ≥ 2 is guaranteed.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- First enabled edge after reset, or any edge with `i_sync_clear`: `o_tick`=1 and `o_clk`=1 from that edge on.
- Steady state: tick-to-tick spacing is exactly N enabled cycles. `o_clk` rises on the tick edge and falls H enabled cycles later.
- Load latency:
  - A new divisor takes effect 1..N cycles after the load edge, at the next wrap.
  - With `i_sync_clear` it takes effect on the next edge.
- Reset asserted mid-period: the next edge returns everything to reset values and the pending load is discarded.
- Enable dropped mid-period: the phase is preserved and resumes exactly where it stopped.

## Structure
- Shared package `clk_div_pkg`:
  - `DIV_MIN` = 2.
  - Helper function `high_len(N)` returning ceil(N/2), reused by the PWM and scan blocks.
- No sub-module is required. The counter, shadow register and output flops are one module, 120–200 lines.

## Test plan
Run with DEFAULT_DIV=4 and WIDTH=8.
- Reset then enable held high:
  - `o_tick` pulses on cycles 1, 5, 9, …
  - `o_clk` pattern is 1,1,0,0 repeating.
  - `o_div_active`=4.
- Load 5 mid-period (`cnt`=1):
  - The current period still lasts 4 cycles.
  - Following periods are 5 cycles, with `o_clk` pattern 1,1,1,0,0.
  - `o_div_active` changes exactly at the wrap.
- Load 0, then load 1:
  - `o_div_err` pulses for one cycle each time.
  - The divisor stays at 4 and the waveform is unchanged.
- Drop enable for 3 cycles at `cnt`=2:
  - `o_clk` holds at 0 and no tick occurs.
  - After resume the next tick arrives 2 enabled cycles later.
- Load 6 and pulse `i_sync_clear` in the same cycle:
  - Next edge gives `o_tick`=1, `o_clk`=1 and `o_div_active`=6.
  - The period is then 6 cycles, with 3 high and 3 low.
- Load 7, then assert reset before the wrap:
  - `o_div_active` returns to 4 and the pending 7 is never applied.
  - All outputs read 0 after the reset edge.
